// File: rtl/ahb_slave_mem.sv
// AHB slave memory: one data phase per accepted transfer, WAIT_STATES wait cycles on OKAY, two-cycle ERROR on illegal size/alignment.
// Read data is registered at the address-phase edge (with write forwarding); stalls via hreadyout, no accept during WAIT/ERR1.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter int WAIT_STATES   = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [31:0]           hrdata,
  output logic [1:0]            hresp
);

  localparam int WA_BITS = MEM_ADDR_BITS - 2;
  localparam int DEPTH   = 1 << WA_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic [WA_BITS-1:0] r_waddr;
  logic [1:0]         r_off;
  logic [2:0]         r_size;
  logic               r_write;
  logic [31:0]        r_hrdata;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept_slot;
  logic               w_accept;
  logic               w_err;
  logic               w_commit;
  logic [3:0]         w_lanes;
  logic [WA_BITS-1:0] w_in_waddr;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_fwd_word;
  logic               w_unused;

  assign w_unused = ^{hburst, hprot, hmastlock, htrans[0], haddr[ADDR_WIDTH-1:MEM_ADDR_BITS]};

  assign w_accept_slot = (r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2);
  assign w_accept      = hselx & hready & htrans[1] & w_accept_slot;
  assign w_err         = (hsize > 3'd2) |
                         ((hsize == 3'd1) & haddr[0]) |
                         ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign w_commit      = (r_state == S_DATA) & r_write;
  assign w_in_waddr    = haddr[MEM_ADDR_BITS-1:2];
  assign w_rd_word     = r_mem[w_in_waddr];

  always_comb begin
    w_lanes = 4'b0000;
    case (r_size)
      3'd0:    w_lanes = 4'b0001 << r_off;
      3'd1:    w_lanes = r_off[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_lanes = 4'b1111;
      default: w_lanes = 4'b0000;
    endcase
  end

  // A read accepted while the previous write commits must see that write's lanes.
  always_comb begin
    w_fwd_word = w_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (w_commit && (r_waddr == w_in_waddr) && w_lanes[i]) begin
        w_fwd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) begin
          r_mem[r_waddr][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    hreadyout   = 1'b1;
    hresp       = 2'b00;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (r_state == S_ERR2) begin
          hresp = 2'b01;
        end
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = 2'b01;
        w_state_nxt = S_ERR2;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_waddr  <= '0;
      r_off    <= 2'b00;
      r_size   <= 3'd0;
      r_write  <= 1'b0;
      r_hrdata <= 32'h0;
    end else if (w_accept) begin
      r_waddr <= w_in_waddr;
      r_off   <= haddr[1:0];
      r_size  <= hsize;
      r_write <= hwrite;
      if (!w_err && !hwrite) begin
        r_hrdata <= w_fwd_word;
      end
    end
  end

  assign hrdata = r_hrdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) driven by a pipelined AHB master,
// checked against a byte-array memory model.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        force_lo;
  logic        hready0, hready1;
  logic        hreadyout0, hreadyout1;
  logic [31:0] hrdata0, hrdata1;
  logic [1:0]  hresp0, hresp1;

  always #5 hclk = ~hclk;

  assign hready0 = hreadyout0 & ~force_lo;
  assign hready1 = hreadyout1 & ~force_lo;

  ahb_slave_mem #(.ADDR_WIDTH(32), .MEM_ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready(hready0), .hreadyout(hreadyout0), .hrdata(hrdata0), .hresp(hresp0)
  );

  ahb_slave_mem #(.ADDR_WIDTH(32), .MEM_ADDR_BITS(10), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready(hready1), .hreadyout(hreadyout1), .hrdata(hrdata1), .hresp(hresp1)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  op_t         q[$];
  logic [7:0]  mdl [2][1024];
  logic [31:0] last_rd [2];
  int          wait_cfg [2] = '{0, 3};
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [2:0] s, input logic [31:0] a);
    return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mdl_word(input int sel, input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {mdl[sel][b+3], mdl[sel][b+2], mdl[sel][b+1], mdl[sel][b]};
  endfunction

  task automatic mdl_write(input int sel, input op_t op);
    int nb, base, w;
    nb   = 1 << op.size;
    base = int'(op.addr[1:0]) & ~(nb - 1);
    w    = int'(op.addr[9:2]) * 4;
    for (int k = base; k < base + nb; k++) begin
      mdl[sel][w+k] = op.wdata[8*k +: 8];
    end
  endtask

  task automatic add_op(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
    op_t op;
    op.wr = wr; op.addr = addr; op.size = size; op.wdata = wdata;
    q.push_back(op);
  endtask

  task automatic drive_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
  endtask

  task automatic drive_addr(input int sel, input op_t op);
    hsel0 = (sel == 0); hsel1 = (sel == 1);
    htrans = 2'b10; haddr = op.addr; hwrite = op.wr; hsize = op.size;
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
  endtask

  // Pipelined master: next address phase overlaps the current data phase whenever the slave is ready.
  task automatic run(input int sel);
    op_t         d;
    bit          dv, err;
    int          i, lows, guard;
    logic        ro;
    logic [1:0]  rs;
    logic [31:0] rd, exp;
    dv = 0; i = 0; lows = 0; guard = 0;
    while ((dv || i < q.size()) && guard < 4000) begin
      @(negedge hclk);
      guard++;
      ro = (sel == 0) ? hreadyout0 : hreadyout1;
      rs = (sel == 0) ? hresp0 : hresp1;
      rd = (sel == 0) ? hrdata0 : hrdata1;
      hwdata = (dv && d.wr) ? d.wdata : 32'($urandom);
      err = dv && is_err(d.size, d.addr);
      if (dv && !ro) begin
        lows++;
        chk("resp_stall", {30'd0, rs}, err ? 32'd1 : 32'd0);
      end
      if (ro) begin
        if (dv) begin
          chk("stall_cycles", 32'(lows), err ? 32'd1 : 32'(wait_cfg[sel]));
          chk("resp_done", {30'd0, rs}, err ? 32'd1 : 32'd0);
          if (!d.wr && !err) begin
            exp = mdl_word(sel, d.addr);
            last_rd[sel] = exp;
          end else begin
            exp = last_rd[sel];
          end
          chk("hrdata", rd, exp);
          if (d.wr && !err) mdl_write(sel, d);
        end
        lows = 0;
        if (i < q.size()) begin
          d = q[i];
          i++;
          dv = 1;
          drive_addr(sel, d);
        end else begin
          dv = 0;
          drive_idle();
        end
      end
    end
    chk("ops_issued", 32'(i), 32'(q.size()));
    chk("drained", {31'd0, dv}, 32'd0);
    q.delete();
  endtask

  initial begin
    hreset = 1'b1; force_lo = 1'b0; hwdata = 32'h0;
    hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
    drive_idle();
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    #12;
    chk("rst_rdy0", {31'd0, hreadyout0}, 32'd1);
    chk("rst_resp0", {30'd0, hresp0}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'h0);
    chk("rst_rdy1", {31'd0, hreadyout1}, 32'd1);
    chk("rst_rdata1", hrdata1, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;

    add_op(1, 32'h010, 3'd2, 32'hDEADBEEF);
    add_op(0, 32'h010, 3'd2, 32'h0);
    run(0);
    chk("wr_rd_word", hrdata0, 32'hDEADBEEF);

    add_op(1, 32'h020, 3'd0, 32'h00000011);
    add_op(1, 32'h021, 3'd0, 32'h00002200);
    add_op(1, 32'h022, 3'd1, 32'h44330000);
    add_op(0, 32'h020, 3'd2, 32'h0);
    run(0);
    chk("byte_half_merge", hrdata0, 32'h44332211);

    add_op(1, 32'h030, 3'd2, 32'hA5A5A5A5);
    add_op(0, 32'h030, 3'd2, 32'h0);
    run(0);
    chk("forward", hrdata0, 32'hA5A5A5A5);

    add_op(1, 32'h000, 3'd2, 32'h12345678);
    add_op(1, 32'h002, 3'd2, 32'hFFFFFFFF);
    add_op(0, 32'h000, 3'd2, 32'h0);
    run(0);
    chk("err_no_write", hrdata0, 32'h12345678);

    add_op(1, 32'h010, 3'd2, 32'h0BADF00D);
    add_op(0, 32'h010, 3'd2, 32'h0);
    add_op(0, 32'h010, 3'd2, 32'h0);
    add_op(1, 32'hFFFF_F013, 3'd1, 32'h0);
    run(1);
    chk("ws3_read", hrdata1, 32'h0BADF00D);

    // Reset pulse while a write sits in its wait states.
    @(negedge hclk);
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h010; hsize = 3'd2;
    @(negedge hclk);
    drive_idle();
    hwdata = 32'hCAFEF00D;
    chk("wait_low", {31'd0, hreadyout1}, 32'd0);
    #1 hreset = 1'b1;
    #1;
    chk("rst_mid_rdy", {31'd0, hreadyout1}, 32'd1);
    chk("rst_mid_resp", {30'd0, hresp1}, 32'd0);
    chk("rst_mid_rdata", hrdata1, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    add_op(0, 32'h010, 3'd2, 32'h0);
    run(1);
    chk("rst_dropped_wr", hrdata1, 32'h0BADF00D);

    // Transfer presented while another slave holds hready low, then a BUSY.
    @(negedge hclk);
    force_lo = 1'b1;
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h020; hsize = 3'd2;
    @(negedge hclk);
    chk("hready_lo_ignored", {31'd0, hreadyout1}, 32'd1);
    force_lo = 1'b0;
    htrans = 2'b01;
    @(negedge hclk);
    chk("busy_rdy", {31'd0, hreadyout1}, 32'd1);
    chk("busy_resp", {30'd0, hresp1}, 32'd0);
    chk("busy_rdata", hrdata1, 32'h0BADF00D);
    drive_idle();

    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) add_op(1, 32'h100 + 32'(w * 4), 3'd2, $urandom);
      for (int n = 0; n < 120; n++) begin
        logic [2:0]  sz;
        logic [31:0] a;
        sz = 3'($urandom_range(0, 3));
        if (sz == 3'd3) sz = 3'($urandom_range(3, 7));
        a = {22'($urandom), 10'h100 + 10'($urandom_range(0, 63))};
        add_op(1'($urandom), a, sz, $urandom);
      end
      run(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB slave memory responder for the interconnect's slave ports: it answers transfers routed to one slave index. It accepts AHB address phases and carries out the data phase against an internal byte-addressable memory of 2^MEM_ADDR_BITS bytes. It inserts a configurable number of wait states and returns the two-cycle ERROR response for illegal transfers. One instance sits behind each slave port of the interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- MEM_ADDR_BITS, 10 (= SLAVE_MEMORY_SIZE), log2 of memory size in bytes; only haddr[MEM_ADDR_BITS-1:0] is decoded
- WAIT_STATES, 0, wait cycles per OKAY data phase, legal range 0..15

Ports:
- hclk  in  1  clock; all state changes on the rising edge
- hreset  in  1  reset; asynchronous and active-high
- hselx  in  1  slave select from interconnect
- haddr  in  ADDR_WIDTH  address phase address
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size (0 byte, 1 half, 2 word)
- hburst  in  3  burst type; informational, not used for address generation
- hprot  in  4  protection; ignored
- hmastlock  in  1  locked transfer; ignored by this block
- hwdata  in  32  write data, valid in data phase
- hready  in  1  bus-wide ready; address phase sampled only when high
- hreadyout  out  1  slave ready
- hrdata  out  32  read data
- hresp  out  2  00 OKAY, 01 ERROR

## Operation
- Accept condition at a clock edge: hselx & hready & htrans[1]. Latch the following into the data-phase register:
  - word address haddr[MEM_ADDR_BITS-1:2]
  - byte offset haddr[1:0]
  - hsize, hwrite
  - error flag
- IDLE or BUSY with hselx & hready: no accept. The next cycle is a zero-wait OKAY.
- Error flag is set if any of:
  - hsize > 2
  - hsize==1 with haddr[0]==1
  - hsize==2 with haddr[1:0]!=0
- Byte-lane mask, little-endian:
  - byte: lane haddr[1:0]
  - half: lanes {haddr[1],0} and {haddr[1],1}
  - word: all four lanes
- States:
  - IDLE: hreadyout=1, hresp=00. On accept: error → ERR1; else WAIT_STATES==0 → DATA; else WAIT.
  - WAIT: counter loaded with WAIT_STATES-1 on entry; hreadyout=0, hresp=00; decrements each cycle; at 0 → DATA.
  - DATA: hreadyout=1, hresp=00. At the edge a write commits masked hwdata to memory. A new accept at the same edge re-enters ERR1/WAIT/DATA; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=01 → ERR2.
  - ERR2: hreadyout=1, hresp=01. No memory write. Accept at this edge is handled as from DATA; otherwise → IDLE.
- Read data:
  - hrdata is registered at the accept edge of a non-error read: full 32-bit word at the word address.
  - Held unchanged until the next read accept. Not cleared by writes, errors, or idle.
- Forwarding: if a write is committing at the same edge a read is accepted and the word addresses match, hrdata gets the memory word with the committing write's enabled lanes replaced by hwdata lanes.
- Address bits above MEM_ADDR_BITS-1 are ignored (interconnect has already decoded them).

## Timing
- Reset (hreset high, asynchronous): state IDLE, hreadyout=1, hresp=00, hrdata=0, counter=0. Memory contents are not cleared.
- Reset asserted mid data phase or mid error: the pending write is dropped and outputs take reset values immediately. The first accept is possible at the first edge after deassertion.
- Latency: address phase at edge N. With WAIT_STATES=0, data phase completes at edge N+1. With W wait states, hreadyout is low for cycles N+1..N+W and high in cycle N+W+1.
- Error: hreadyout low one cycle, then high one cycle; hresp=01 in both cycles, independent of WAIT_STATES.
- Back-to-back transfers are accepted in DATA/ERR2 cycles without a bubble. No accept is possible in WAIT or ERR1, because hready is low bus-wide.
- hready low from another slave: inputs are ignored; state holds (only IDLE can see this).

## Test plan
- Reset, then word write 0xDEADBEEF @0x010, then word read @0x010, WAIT_STATES=0 → write completes in 1 cycle with hreadyout=1; read hrdata=0xDEADBEEF one cycle after its address phase; hresp=00.
- Byte writes 0x11@0x020, 0x22@0x021, half 0x4433@0x022, then word read @0x020 → 0x44332211.
- Write 0xA5A5A5A5 @0x030 immediately followed by read @0x030 (read address phase overlapping the write data phase) → hrdata=0xA5A5A5A5 via forwarding.
- WAIT_STATES=3: read @0x010 → hreadyout low exactly 3 cycles, then high with correct data; counter reloads for a back-to-back second read.
- Word write @0x002 → hreadyout 0 then 1, hresp=01 for both cycles; the subsequent read @0x000 returns the old value.
- hreset pulse during WAIT of a write → hreadyout=1, hresp=00, hrdata=0 immediately; target word is unchanged afterwards.
